// File: rtl/key_schedule_rev.sv
// key_schedule_rev: AES-128 key expansion serving round keys in decryption order (10..0).
// Optional AES_KEY_REPLAY_EN re-serves the stored schedule without re-expanding.
module key_schedule_rev #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  input  logic         replay,
  output logic         busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_SERVE  = 2'd2;
  if (NR != 10) begin : g_nr_check
    $error("key_schedule_rev supports only NR=10 (AES-128)");
  end
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Forward S-box: inverse as a^254 by square-and-multiply, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, inv;
    s = gmul(a, a);
    inv = s;
    for (int i = 2; i < 8; i++) begin
      s = gmul(s, s);
      inv = gmul(inv, s);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [0:127] expand(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] t, w0, w1, w2, w3;
    t  = {sbox(k[104:111]), sbox(k[112:119]), sbox(k[120:127]), sbox(k[96:103])} ^ {rc, 24'h0};
    w0 = k[0:31] ^ t;
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [7:0]   r_rcon;
  logic [0:127] r_rk [0:10];
  logic [0:127] r_rk_out;
  logic [3:0]   r_rk_round;
  logic         r_rk_valid;
  logic [3:0]   w_prev;
  logic [0:127] w_next;
  logic         w_replay;
  logic         w_key_acc;
  logic         w_last;
`ifdef AES_KEY_REPLAY_EN
  logic r_done;
  assign w_replay = replay && (r_state == S_SERVE || (r_state == S_IDLE && r_done));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else if (r_state == S_SERVE && r_rk_valid && rk_ready && r_cnt == 4'd0) r_done <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused = replay;
  assign w_replay = 1'b0;
`endif
  assign w_prev    = r_cnt - 4'd1;
  assign w_next    = expand(r_rk[w_prev], r_rcon);
  assign w_key_acc = r_state == S_IDLE && key_valid && !w_replay;
  assign w_last    = r_cnt == 4'd0;
  assign key_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign rk_out    = r_rk_out;
  assign rk_round  = r_rk_round;
  assign rk_valid  = r_rk_valid;
  // Key storage needs no reset: it is only read after a full expansion
  always_ff @(posedge clk) begin
    if (w_key_acc) r_rk[0] <= key_in;
    else if (r_state == S_EXPAND) r_rk[r_cnt] <= w_next;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_rcon     <= 8'h00;
      r_rk_out   <= '0;
      r_rk_round <= 4'd0;
      r_rk_valid <= 1'b0;
    end else if (w_replay) begin
      r_state    <= S_SERVE;
      r_cnt      <= 4'd10;
      r_rk_out   <= r_rk[10];
      r_rk_round <= 4'd10;
      r_rk_valid <= 1'b1;
    end else if (w_key_acc) begin
      r_state <= S_EXPAND;
      r_cnt   <= 4'd1;
      r_rcon  <= 8'h01;
    end else if (r_state == S_EXPAND) begin
      r_rcon  <= xtime(r_rcon);
      r_state <= (r_cnt == 4'd10) ? S_SERVE : S_EXPAND;
      r_cnt   <= (r_cnt == 4'd10) ? r_cnt : r_cnt + 4'd1;
    end else if (r_state == S_SERVE && !r_rk_valid) begin
      r_rk_out   <= r_rk[r_cnt];
      r_rk_round <= r_cnt;
      r_rk_valid <= 1'b1;
    end else if (r_state == S_SERVE && rk_ready) begin
      r_state    <= w_last ? S_IDLE : S_SERVE;
      r_cnt      <= w_last ? 4'd0 : w_prev;
      r_rk_out   <= w_last ? '0 : r_rk[w_prev];
      r_rk_round <= w_last ? 4'd0 : w_prev;
      r_rk_valid <= !w_last;
    end
  end
endmodule

// File: tb/tb_key_schedule_rev.sv
// tb_key_schedule_rev: directed FIPS-197 vectors, scoreboard queue checked by a negedge monitor.
module tb_key_schedule_rev;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         replay;
  logic         busy;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         cmp;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           errors = 0;
  int           n;
  logic [127:0] fips [0:10];
  localparam logic [127:0] KEY2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_schedule_rev #(.NR(10)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .replay(replay), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && rk_valid && rk_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected round key: got round %0d data %h, expected none", rk_round, rk_out);
      end else begin
        e = exp_q.pop_front();
        chk("rk_round", {124'h0, rk_round}, {124'h0, e.rnd});
        if (e.cmp) chk($sformatf("rk_out round %0d", e.rnd), rk_out, e.key);
      end
    end
  end

  task automatic push_fips();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = fips[r];
      e.cmp = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_key2();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = (r == 10) ? K2R10 : KEY2;
      e.cmp = (r == 10 || r == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 50 && !key_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("key_ready before send", {127'h0, key_ready}, 128'h1);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic pulse_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!rk_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("rk_valid rise", {127'h0, rk_valid}, 128'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard drained", 128'(exp_q.size()), 128'h0);
    exp_q.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " key_ready"}, {127'h0, key_ready}, 128'h1);
    chk({tag, " rk_valid"}, {127'h0, rk_valid}, 128'h0);
    chk({tag, " rk_out"}, rk_out, 128'h0);
    chk({tag, " rk_round"}, {124'h0, rk_round}, 128'h0);
    chk({tag, " busy"}, {127'h0, busy}, 128'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_in = '0;
    key_valid = 1'b0;
    rk_ready = 1'b0;
    replay = 1'b0;
    #2 reset = 1'b0;
    #10;
    chk_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    // nominal stream with latency and handshake checks
    rk_ready = 1'b1;
    push_fips();
    send_key(fips[0]);
    chk("busy in expand", {127'h0, busy}, 128'h1);
    chk("key_ready in expand", {127'h0, key_ready}, 128'h0);
    wait_valid(n);
    chk("accept to rk_valid cycles", 128'(n), 128'd11);
    drain();
    chk("key_ready after round 0", {127'h0, key_ready}, 128'h1);
    chk("rk_valid after round 0", {127'h0, rk_valid}, 128'h0);
    // consumer stall at round 10
    rk_ready = 1'b0;
    push_fips();
    send_key(fips[0]);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("stall rk_round", {124'h0, rk_round}, 128'd10);
      chk("stall rk_out", rk_out, fips[10]);
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    drain();
    // stray keys during EXPAND and SERVE must be ignored
    push_fips();
    send_key(fips[0]);
    repeat (3) @(posedge clk);
    #1;
    pulse_key(KEY2);
    wait_valid(n);
    repeat (2) @(posedge clk);
    #1;
    pulse_key(KEY2);
    drain();
    // asynchronous reset while serving round 6
    push_fips();
    send_key(fips[0]);
    for (int i = 0; i < 60 && !(rk_valid && rk_round == 4'd6); i++) begin
      @(posedge clk); #1;
    end
    chk("reached round 6", {127'h0, rk_valid && rk_round == 4'd6}, 128'h1);
    #2 reset = 1'b0;
    #1;
    chk_reset_values("async reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    push_key2();
    send_key(KEY2);
    drain();
    // replay pulse after round 0 has been consumed
    rk_ready = 1'b0;
    replay = 1'b1;
    @(posedge clk); #1;
    replay = 1'b0;
`ifdef AES_KEY_REPLAY_EN
    chk("replay rk_valid", {127'h0, rk_valid}, 128'h1);
    chk("replay rk_round", {124'h0, rk_round}, 128'd10);
    chk("replay rk_out", rk_out, K2R10);
    chk("replay busy", {127'h0, busy}, 128'h1);
    push_key2();
    rk_ready = 1'b1;
    drain();
`else
    for (int i = 0; i < 3; i++) begin
      chk("replay ignored rk_valid", {127'h0, rk_valid}, 128'h0);
      chk("replay ignored key_ready", {127'h0, key_ready}, 128'h1);
      chk("replay ignored busy", {127'h0, busy}, 128'h0);
      @(posedge clk); #1;
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
